// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
// Optional feature macro: MULDIV_DIV_EN enables the divider and its state.
package muldiv_pkg;

    // R-type funct codes handled by the sequencer
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    // Default iteration count (one iteration per operand bit)
    localparam int unsigned MULDIV_ITERS = 32;

    // Iteration counter width; covers operand widths up to 64
    localparam int unsigned CNT_W = 6;

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StFix  = 2'd3
    } muldiv_state_t;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StFix  = 2'd3
    } muldiv_state_t;
`endif

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between decode/EX and the multiply/divide sequencer.
interface muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, funct, rs_val, rt_val,
        input  req_ready, hi, lo, busy, done
    );

    modport slave (
        input  req_valid, funct, rs_val, rt_val,
        output req_ready, hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_ctrl_step.sv
// Single iteration of the radix-2 shift-add multiplier / restoring divider.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {remainder, dividend/quotient bits}.
// Optional feature macro: MULDIV_DIV_EN compiles in the divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_ITERS
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_next;
`else
    logic unused_div;
    assign unused_div = div_i;
`endif

    // Next accumulator for the selected mode
    always_comb begin
        mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Carry out of the add lands in the top bit after the shift
        mul_next = {mul_sum, acc_i[WIDTH-1:1]};
        acc_o    = mul_next;
        qbit_o   = 1'b0;
`ifdef MULDIV_DIV_EN
        // Shifted remainder needs one extra bit before the trial subtract
        rem_sh   = acc_i[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, operand_i};
        rem_ge   = (rem_sh >= {1'b0, operand_i});
        div_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                    acc_i[WIDTH-2:0], rem_ge};
        if (div_i) begin
            acc_o  = div_next;
            qbit_o = rem_ge;
        end
`endif
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Signed operations run on magnitudes; signs are fixed up in one final cycle.
// Optional feature macro: MULDIV_DIV_EN enables div/divu (otherwise they are no-ops).
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_ITERS
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_ctrl_if.slave  bus
);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_quot_q, neg_quot_d;
    logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
`endif

    logic               accept;
    logic               signed_op;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_div;
    logic               unused_step_qbit;

`ifdef MULDIV_DIV_EN
    assign step_div = (state_q == StDiv);
`else
    assign step_div = 1'b0;
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i     (acc_q),
        .operand_i (op_q),
        .div_i     (step_div),
        .acc_o     (step_acc),
        .qbit_o    (unused_step_qbit)
    );

    // Request decode and operand magnitudes
    always_comb begin
        accept    = bus.req_valid && (state_q == StIdle);
        signed_op = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
        rs_neg    = signed_op && bus.rs_val[WIDTH-1];
        rt_neg    = signed_op && bus.rt_val[WIDTH-1];
        rs_abs    = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_abs    = rt_neg ? -bus.rt_val : bus.rt_val;
        prod      = neg_quot_q ? -acc_q : acc_q;
    end

    // Next-state logic for the sequencer and HI/LO
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_quot_d = neg_quot_q;
        done_d     = 1'b0;
`ifdef MULDIV_DIV_EN
        neg_rem_d  = neg_rem_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.funct)
                        FN_MTHI: hi_d = bus.rs_val;
                        FN_MTLO: lo_d = bus.rs_val;
                        FN_MULT, FN_MULTU: begin
                            op_d       = rs_abs;
                            acc_d      = {{WIDTH{1'b0}}, rt_abs};
                            neg_quot_d = rs_neg ^ rt_neg;
                            cnt_d      = '0;
`ifdef MULDIV_DIV_EN
                            neg_rem_d  = 1'b0;
                            is_div_d   = 1'b0;
                            dz_d       = 1'b0;
`endif
                            state_d    = StMul;
                        end
`ifdef MULDIV_DIV_EN
                        FN_DIV, FN_DIVU: begin
                            cnt_d    = '0;
                            is_div_d = 1'b1;
                            if (bus.rt_val == '0) begin
                                // Divide by zero: results are staged in acc directly
                                acc_d      = {bus.rs_val, {WIDTH{1'b1}}};
                                neg_quot_d = 1'b0;
                                neg_rem_d  = 1'b0;
                                dz_d       = 1'b1;
                                state_d    = StFix;
                            end else begin
                                op_d       = rt_abs;
                                acc_d      = {{WIDTH{1'b0}}, rs_abs};
                                neg_quot_d = rs_neg ^ rt_neg;
                                neg_rem_d  = rs_neg;
                                dz_d       = 1'b0;
                                state_d    = StDiv;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef MULDIV_DIV_EN
            StMul, StDiv: begin
`else
            StMul: begin
`endif
                acc_d = step_acc;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (dz_q) begin
                    hi_d = acc_q[2*WIDTH-1:WIDTH];
                    lo_d = acc_q[WIDTH-1:0];
                end else if (is_div_q) begin
                    lo_d = neg_quot_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = prod;
                end
`else
                {hi_d, lo_d} = prod;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // All sequencer state; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_quot_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_quot_q <= neg_quot_d;
            done_q     <= done_d;
`ifdef MULDIV_DIV_EN
            neg_rem_q  <= neg_rem_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
`endif
        end
    end

    // Handshake and result outputs
    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.busy      = (state_q != StIdle);
        bus.done      = done_q;
        bus.hi        = hi_q;
        bus.lo        = lo_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with hand-computed results.
// Divide vectors run when MULDIV_DIV_EN is defined; otherwise div/divu are
// checked to be no-ops.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(
        .WIDTH (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one request at a negedge, then wait for busy to drop and check results
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] ehi,
                          input logic [31:0] elo, input int ebusy);
        int nb;
        check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.funct     = fn;
        bus.rs_val    = rs;
        bus.rt_val    = rt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        nb = 0;
        while (bus.busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(nb), 64'(ebusy));
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(elo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int nb;
        int seen_done;
        logic [5:0] div_fns [2];
        logic [31:0] div_rts [2];
        div_fns[0] = FN_DIV;  div_rts[0] = 32'd2;
        div_fns[1] = FN_DIVU; div_rts[1] = 32'd0;

        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.funct     = 6'h00;
        bus.rs_val    = '0;
        bus.rt_val    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back mthi then mtlo
        bus.req_valid = 1'b1;
        bus.funct     = FN_MTHI;
        bus.rs_val    = 32'h55;
        @(negedge clk);
        check("mthi_hi", 64'(bus.hi), 64'h55);
        check("mthi_ready", 64'(bus.req_ready), 64'd1);
        bus.funct  = FN_MTLO;
        bus.rs_val = 32'h66;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'h66);
        check("mtlo_hi", 64'(bus.hi), 64'h55);
        check("mtlo_done", 64'(bus.done), 64'd0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);

        // Multiplies
        run_op("mult_neg3x5", FN_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        run_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
               32'h0000_0001, 33);
        run_op("mult_min_x2", FN_MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0, 33);

`ifdef MULDIV_DIV_EN
        run_op("div_neg7_2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div_7_neg2", FN_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_op("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("divu_zero", FN_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1);
        run_op("div_zero_neg", FN_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);
`else
        // Divide disabled: accepted with no effect; HI/LO still hold mult_min_x2 result
        for (int i = 0; i < 2; i++) begin
            check("nodiv_ready", 64'(bus.req_ready), 64'd1);
            bus.req_valid = 1'b1;
            bus.funct     = div_fns[i];
            bus.rs_val    = 32'hFFFF_FFF9;
            bus.rt_val    = div_rts[i];
            @(negedge clk);
            bus.req_valid = 1'b0;
            check("nodiv_busy", 64'(bus.busy), 64'd0);
            check("nodiv_done", 64'(bus.done), 64'd0);
            check("nodiv_hi", 64'(bus.hi), 64'hFFFF_FFFF);
            check("nodiv_lo", 64'(bus.lo), 64'h0);
            @(negedge clk);
            check("nodiv_done2", 64'(bus.done), 64'd0);
        end
`endif

        // Backpressure: mthi held while a multu is in flight
        bus.req_valid = 1'b1;
        bus.funct     = FN_MULTU;
        bus.rs_val    = 32'd2;
        bus.rt_val    = 32'd3;
        begin
            logic [31:0] hi_before;
            hi_before = bus.hi;
            @(negedge clk);
            bus.funct  = FN_MTHI;
            bus.rs_val = 32'hAA;
            nb = 0;
            while (bus.busy && nb < 100) begin
                check("bp_ready_low", 64'(bus.req_ready), 64'd0);
                check("bp_hi_hold", 64'(bus.hi), 64'(hi_before));
                nb++;
                @(negedge clk);
            end
        end
        check("bp_busy_cycles", 64'(nb), 64'd33);
        check("bp_done", 64'(bus.done), 64'd1);
        check("bp_ready", 64'(bus.req_ready), 64'd1);
        check("bp_mul_hi", 64'(bus.hi), 64'h0);
        check("bp_mul_lo", 64'(bus.lo), 64'd6);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("bp_mthi_hi", 64'(bus.hi), 64'hAA);
        check("bp_mthi_lo", 64'(bus.lo), 64'd6);
        check("bp_mthi_busy", 64'(bus.busy), 64'd0);
        check("bp_mthi_done", 64'(bus.done), 64'd0);

        // Reset in the middle of a multiply
        bus.req_valid = 1'b1;
        bus.funct     = FN_MULT;
        bus.rs_val    = 32'd5;
        bus.rt_val    = 32'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst_busy_before", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'h0);
        check("midrst_lo", 64'(bus.lo), 64'h0);
        check("midrst_ready", 64'(bus.req_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done++;
        end
        check("midrst_no_done", 64'(seen_done), 64'd0);
        run_op("post_rst_multu", FN_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It sits beside the main ALU in EX and accepts R-type mult/multu/div/divu/mthi/mtlo requests from decode. It runs a radix-2 shift-add or restoring-divide loop over 32 cycles and signals hazard logic through `busy`/`req_ready` so that mfhi/mflo and new requests stall until results land.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, 1: request present this cycle.
- `req_ready`, output, 1: request is accepted on a rising edge when `req_valid && req_ready`.
- `funct`, input, 6: R-type funct field. 0x18 = mult, 0x19 = multu, 0x1A = div, 0x1B = divu, 0x11 = mthi, 0x13 = mtlo.
- `rs_val`, input, WIDTH: rs operand (dividend, multiplicand, or mthi/mtlo data).
- `rt_val`, input, WIDTH: rt operand (divisor or multiplier).
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.
- `busy`, output, 1: an operation is in flight, so HI/LO are stale. Decode must stall mfhi/mflo while this is high.
- `done`, output, 1: one-cycle pulse in the cycle in which new HI/LO first become visible.

## Operation
- States: IDLE, MUL, DIV, FIX.
- `req_ready = (state == IDLE)`.
- **IDLE, accepted request:**
  - mthi/mtlo: write `hi` or `lo` from `rs_val` at the accept edge. Stay in IDLE, no `done`.
  - mult/div: latch |rs| and |rt| (absolute values for signed ops, raw values for unsigned ops). Latch `neg_q = sign(rs) ^ sign(rt)` and `neg_r = sign(rs)`, both forced to 0 for unsigned ops. Clear the 6-bit counter and go to MUL or DIV.
  - div/divu with `rt_val == 0`: go directly to FIX with the divide-by-zero flag set.
  - Any other funct: accepted, no effect.
- **MUL:** each cycle, if acc_lo[0] is set, add the multiplicand into the upper half. Then shift the 2·WIDTH accumulator right by 1. After WIDTH iterations go to FIX.
- **DIV:** restoring divide. Shift {rem, quot} left by 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quot[0]. After WIDTH iterations go to FIX.
- **FIX:** one cycle, then return to IDLE.
  - Multiply: {hi, lo} = neg_q ? −acc : acc (2·WIDTH-bit two's complement).
  - Divide: lo = neg_q ? −quot : quot and hi = neg_r ? −rem : rem.
  - Divide by zero: hi = rs_val as latched, lo = all-ones.
  - All arithmetic wraps modulo 2^WIDTH. INT_MIN / −1 gives lo = 0x80000000, hi = 0.
- `busy = (state != IDLE)`.
- `done` is registered and set on the FIX→IDLE edge.
- HI/LO change only at the FIX exit edge or at an mthi/mtlo accept edge.

## Timing
- Reset (async, `rst_n` low): state = IDLE, `hi` = 0, `lo` = 0, `done` = 0, counter = 0. Outputs therefore read `busy` = 0 and `req_ready` = 1.
- Reset asserted mid-operation aborts the operation. HI/LO return to 0 and no `done` is produced.
- Mult/div latency, with the accept edge as E0:
  - Iterations occur on E1..E32.
  - FIX commits HI/LO on E33.
  - `done` is high and `busy` low for the cycle after E33, and a new request can be accepted on E34.
  - Total: 34 cycles from accept to usable result; `busy` is high for 33 cycles.
- Divide by zero: E0 accept, E1 FIX commit, `done` in the cycle after E1.
- mthi/mtlo: the value is visible the cycle after the accept edge. Back-to-back mthi requests are allowed every cycle.
- A request presented while `busy` is not accepted. The requester must hold `req_valid`, `funct` and the operands stable until accepted.
- `done` and `req_ready` are both high in the same cycle after FIX, so a new request can be accepted on that edge.

## Configuration
- `MULDIV_DIV_EN` defined: the full feature set above.
- `MULDIV_DIV_EN` undefined:
  - The DIV state, divider step logic and divide-by-zero path are compiled out.
  - funct 0x1A/0x1B are treated as "any other funct": accepted, no effect, no `done`, and HI/LO unchanged.
  - Multiply, mthi and mtlo are unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - funct constants `FN_MULT`, `FN_MULTU`, `FN_DIV`, `FN_DIVU`, `FN_MTHI`, `FN_MTLO`;
  - the state enum `muldiv_state_t`;
  - the iteration count constant.
- One sub-module, `muldiv_step`: combinational single-iteration datapath. It takes the accumulator, operand and mode (mul/div) and returns the next accumulator plus the quotient bit. `muldiv_ctrl` holds the FSM, the counter, sign flags and the HI/LO registers.

## Test plan
- **Signed multiply:** mult rs = 0xFFFFFFFD (−3), rt = 5 → `busy` is high for 33 cycles, then `done`, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- **Unsigned multiply:** multu 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- **Signed divide and overflow case:**
  - div rs = 0xFFFFFFF9 (−7), rt = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero:** divu rs = 0x1234, rt = 0 → `done` 2 cycles after accept, hi = 0x1234, lo = 0xFFFFFFFF.
- **Backpressure:** issue mult, then hold mthi 0xAA with `req_valid` high while `busy` → `req_ready` stays 0 and HI is unchanged until `done`. mthi is accepted on E34, and hi = 0xAA the next cycle.
- **Reset mid-operation:** drop `rst_n` 10 cycles into a mult → hi = lo = 0, `busy` = 0 immediately, no `done`. After release, a new multu 3 × 4 yields lo = 12.
